// File: rtl/axis_2_fifo_packer_pkg.sv
// Shared helpers for the AXIS-to-wide-FIFO packer: index sizing and word-layout offsets.
// Word layout, LSB first: data lanes, keep lanes, last, user (MSB).
package axis_2_fifo_packer_pkg;

   localparam int DEF_AXIS_DATA_WIDTH = 32;
   localparam int DEF_PACK_RATIO      = 2;

   // Bits needed to count 0..n-1, never less than one so a ratio of 1 still has an index.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int data_lane_lo(input int lane, input int data_w);
      return lane * data_w;
   endfunction

   function automatic int keep_lane_lo(input int lane, input int data_w, input int keep_w,
                                       input int ratio);
      return ratio * data_w + lane * keep_w;
   endfunction

   function automatic int last_bit_of(input int fifo_w);
      return fifo_w - 2;
   endfunction

   function automatic int user_bit_of(input int fifo_w);
      return fifo_w - 1;
   endfunction

endpackage

// File: rtl/axis_2_fifo_packer_out_reg.sv
// Output holding register: loads a finished word, keeps it until the FIFO can take it.
// Latency 1 cycle from load to visible word; upstream is held off only while a word is stuck.
module axis_packer_out_reg #(
   parameter int WIDTH = 74
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             can_write,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] out_data,
   output logic             w_stb,
   output logic             in_rdy
);

   logic out_valid;

   assign w_stb  = out_valid & can_write;
   assign in_rdy = ~out_valid | can_write;

   // load only happens while in_rdy, so a stalled word is never overwritten;
   // a load in the same cycle as a write simply replaces the departing word.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (w_stb) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_2_fifo_packer.sv
// Packs PACK_RATIO narrow AXIS beats (or fewer, on tlast) into one wide FIFO word.
// Word appears 1 cycle after the completing beat; any held-off word stalls all AXIS beats.
module axis_2_fifo_packer
   import axis_2_fifo_packer_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int PACK_RATIO      = DEF_PACK_RATIO,
   parameter int FIFO_DATA_WIDTH = PACK_RATIO * (AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH) + 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_axis_tuser,
   input  logic                       i_axis_tvalid,
   output logic                       o_axis_tready,
   input  logic                       i_axis_tlast,
   input  logic [AXIS_KEEP_WIDTH-1:0] i_axis_tkeep,
   input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
   output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
   output logic                       o_fifo_w_stb,
   input  logic                       i_fifo_full,
   input  logic                       i_fifo_not_full,
   output logic [31:0]                o_pkt_count
);

   localparam int IDX_W    = clog2_min1(PACK_RATIO);
   localparam int LAST_BIT = last_bit_of(FIFO_DATA_WIDTH);
   localparam int USER_BIT = user_bit_of(FIFO_DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PACK_RATIO - 1);

   logic [FIFO_DATA_WIDTH-1:0] acc_q;
   logic [FIFO_DATA_WIDTH-1:0] word_next;
   logic                       user_acc_q;
   logic [IDX_W-1:0]           idx_q;
   logic                       can_write;
   logic                       in_rdy;
   logic                       accept;
   logic                       complete;

   // Conflicting full/not_full flags resolve to "full".
   assign can_write     = i_fifo_not_full & ~i_fifo_full;
   assign o_axis_tready = in_rdy;
   assign accept        = i_axis_tvalid & in_rdy;
   assign complete      = accept & ((idx_q == IDX_MAX) | i_axis_tlast);

   // Current beat merged into the accumulator; lanes not yet written are still zero.
   always_comb begin
      word_next = acc_q;
      for (int l = 0; l < PACK_RATIO; l++) begin
         if (idx_q == IDX_W'(l)) begin
            word_next[data_lane_lo(l, AXIS_DATA_WIDTH) +: AXIS_DATA_WIDTH] = i_axis_tdata;
            word_next[keep_lane_lo(l, AXIS_DATA_WIDTH, AXIS_KEEP_WIDTH, PACK_RATIO)
                      +: AXIS_KEEP_WIDTH] = i_axis_tkeep;
         end
      end
      word_next[LAST_BIT] = i_axis_tlast;
      word_next[USER_BIT] = user_acc_q | i_axis_tuser;
   end

   // The accumulator never holds last/user; those are added only when the word completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         user_acc_q <= 1'b0;
         idx_q      <= '0;
      end else if (complete) begin
         acc_q      <= '0;
         user_acc_q <= 1'b0;
         idx_q      <= '0;
      end else if (accept) begin
         acc_q      <= {2'b00, word_next[LAST_BIT-1:0]};
         user_acc_q <= word_next[USER_BIT];
         idx_q      <= idx_q + 1'b1;
      end
   end

   axis_packer_out_reg #(
      .WIDTH(FIFO_DATA_WIDTH)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .can_write(can_write),
      .load     (complete),
      .load_data(word_next),
      .out_data (o_fifo_data),
      .w_stb    (o_fifo_w_stb),
      .in_rdy   (in_rdy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         o_pkt_count <= 32'd0;
      end else if (o_fifo_w_stb & o_fifo_data[LAST_BIT]) begin
         o_pkt_count <= o_pkt_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_axis_2_fifo_packer.sv
// Bench for axis_2_fifo_packer: PACK_RATIO=2 (unit 0) and PACK_RATIO=4 (unit 1) instances
// checked against a per-unit word scoreboard plus table rows and hand-written corner sequences.
module tb_axis_2_fifo_packer;

   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int FW2 = 2 * (DW + KW) + 2;
   localparam int FW4 = 4 * (DW + KW) + 2;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic        u;
      int          exp_words;
      int          exp_pkts;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        vld  [2];
   logic        lst  [2];
   logic        usr  [2];
   logic [3:0]  keep [2];
   logic [31:0] dat  [2];
   logic        rdy  [2];
   logic        stb  [2];
   logic        full [2];
   logic        nf   [2];
   logic [31:0] cnt  [2];
   logic [FW2-1:0] fd2;
   logic [FW4-1:0] fd4;

   axis_2_fifo_packer #(.AXIS_DATA_WIDTH(DW), .PACK_RATIO(2)) dut2 (
      .clk(clk), .rst(rst),
      .i_axis_tuser(usr[0]), .i_axis_tvalid(vld[0]), .o_axis_tready(rdy[0]),
      .i_axis_tlast(lst[0]), .i_axis_tkeep(keep[0]), .i_axis_tdata(dat[0]),
      .o_fifo_data(fd2), .o_fifo_w_stb(stb[0]),
      .i_fifo_full(full[0]), .i_fifo_not_full(nf[0]), .o_pkt_count(cnt[0])
   );

   axis_2_fifo_packer #(.AXIS_DATA_WIDTH(DW), .PACK_RATIO(4)) dut4 (
      .clk(clk), .rst(rst),
      .i_axis_tuser(usr[1]), .i_axis_tvalid(vld[1]), .o_axis_tready(rdy[1]),
      .i_axis_tlast(lst[1]), .i_axis_tkeep(keep[1]), .i_axis_tdata(dat[1]),
      .o_fifo_data(fd4), .o_fifo_w_stb(stb[1]),
      .i_fifo_full(full[1]), .i_fifo_not_full(nf[1]), .o_pkt_count(cnt[1])
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int words [2];

   logic [31:0] m_data [2][4];
   logic [3:0]  m_keep [2][4];
   logic        m_user [2];
   int          m_idx  [2];
   logic [FW4-1:0] q0[$];
   logic [FW4-1:0] q1[$];
   logic [FW4-1:0] exp_w0, exp_w1;
   logic [FW2-1:0] last_w0;
   logic [FW4-1:0] last_w1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [FW4-1:0] got, input logic [FW4-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [FW4-1:0] build_word(input int u, input int top, input logic l,
                                                  input logic us);
      logic [FW4-1:0] w;
      int pr;
      pr = (u == 0) ? 2 : 4;
      w  = '0;
      for (int i = 0; i <= top; i++) begin
         w[i*DW +: DW]         = m_data[u][i];
         w[pr*DW + i*KW +: KW] = m_keep[u][i];
      end
      w[pr*(DW+KW)]     = l;
      w[pr*(DW+KW) + 1] = us;
      return w;
   endfunction

   task automatic model_clear(input int u);
      for (int i = 0; i < 4; i++) begin
         m_data[u][i] = '0;
         m_keep[u][i] = '0;
      end
      m_user[u] = 1'b0;
      m_idx[u]  = 0;
   endtask

   task automatic model_accept(input int u, input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic us);
      int pr;
      pr = (u == 0) ? 2 : 4;
      m_data[u][m_idx[u]] = d;
      m_keep[u][m_idx[u]] = k;
      m_user[u] = m_user[u] | us;
      if (l || m_idx[u] == pr - 1) begin
         if (u == 0) q0.push_back(build_word(u, m_idx[u], l, m_user[u]));
         else        q1.push_back(build_word(u, m_idx[u], l, m_user[u]));
         model_clear(u);
      end else begin
         m_idx[u]++;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat has been taken.
   task automatic beat(input int u, input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic us);
      int waited;
      waited  = 0;
      vld[u]  = 1'b1;
      dat[u]  = d;
      keep[u] = k;
      lst[u]  = l;
      usr[u]  = us;
      @(negedge clk);
      while (!rdy[u] && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!rdy[u]) begin
         errors++;
         $display("FAIL tready_timeout unit=%0d got=0 want=1", u);
      end else begin
         model_accept(u, d, k, l, us);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int u);
      vld[u] = 1'b0;
      lst[u] = 1'b0;
      usr[u] = 1'b0;
   endtask

   task automatic cyc_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: every strobe must match the oldest word the model expects.
   always @(negedge clk) begin
      if (stb[0]) begin
         words[0]++;
         last_w0 = fd2;
         if (q0.size() == 0) begin
            chk("sb0_unexpected_word", {{(FW4-FW2){1'b0}}, fd2}, '1);
         end else begin
            exp_w0 = q0.pop_front();
            chk("sb0_word", {{(FW4-FW2){1'b0}}, fd2}, exp_w0);
         end
      end
      if (stb[1]) begin
         words[1]++;
         last_w1 = fd4;
         if (q1.size() == 0) begin
            chk("sb1_unexpected_word", fd4, '1);
         end else begin
            exp_w1 = q1.pop_front();
            chk("sb1_word", fd4, exp_w1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[12];
      logic [FW2-1:0] hold;
      int st, en, w0;

      tbl[0]  = '{32'h000000A0, 4'hF, 1'b0, 1'b0, 0, 0};
      tbl[1]  = '{32'h000000A1, 4'hF, 1'b0, 1'b0, 0, 0};
      tbl[2]  = '{32'h000000A2, 4'h3, 1'b1, 1'b0, 1, 1};
      tbl[3]  = '{32'h000000B0, 4'hF, 1'b0, 1'b0, 1, 1};
      tbl[4]  = '{32'h000000B1, 4'hF, 1'b0, 1'b1, 1, 1};
      tbl[5]  = '{32'h000000B2, 4'h0, 1'b0, 1'b0, 1, 1};
      tbl[6]  = '{32'h000000B3, 4'hF, 1'b0, 1'b0, 2, 1};
      tbl[7]  = '{32'h000000C0, 4'hF, 1'b1, 1'b0, 3, 2};
      tbl[8]  = '{32'h000000D0, 4'hF, 1'b0, 1'b0, 3, 2};
      tbl[9]  = '{32'h000000D1, 4'hF, 1'b0, 1'b0, 3, 2};
      tbl[10] = '{32'h000000D2, 4'hF, 1'b0, 1'b0, 3, 2};
      tbl[11] = '{32'h000000D3, 4'hF, 1'b1, 1'b0, 4, 3};

      words[0] = 0;
      words[1] = 0;
      for (int u = 0; u < 2; u++) begin
         idle(u);
         dat[u]  = '0;
         keep[u] = '0;
         full[u] = 1'b0;
         nf[u]   = 1'b1;
         model_clear(u);
      end
      rst = 1'b1;
      cyc_n(3);

      @(negedge clk);
      chk("reset_tready0", rdy[0], 1);
      chk("reset_stb0",    stb[0], 0);
      chk("reset_data0",   fd2,    0);
      chk("reset_cnt0",    cnt[0], 0);
      chk("reset_tready1", rdy[1], 1);
      chk("reset_data1",   fd4,    0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Two-beat packet on the ratio-2 unit.
      beat(0, 32'h11111111, 4'hF, 1'b0, 1'b0);
      beat(0, 32'h22222222, 4'hF, 1'b1, 1'b0);
      idle(0);
      cyc_n(2);
      chk("basic_word",  last_w0, {1'b0, 1'b1, 8'hFF, 64'h22222222_11111111});
      chk("basic_cnt",   cnt[0], 1);
      chk("basic_words", words[0], 1);

      // Ratio-4 table: short packets, keep-zero beat, sticky tuser, tlast on lane 0.
      for (int i = 0; i < 12; i++) begin
         beat(1, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u);
         idle(1);
         cyc_n(2);
         chk($sformatf("tbl%0d_words", i), words[1], tbl[i].exp_words);
         chk($sformatf("tbl%0d_pkts", i),  cnt[1],   tbl[i].exp_pkts);
         if (i == 2)
            chk("tbl_short_word", last_w1,
                {1'b0, 1'b1, 16'h03FF, 128'h00000000_000000A2_000000A1_000000A0});
         if (i == 6) chk("tbl_user_set",   last_w1[FW4-1], 1);
         if (i == 7) chk("tbl_user_clear", last_w1[FW4-1], 0);
      end

      // Stall: word held while the FIFO is not ready, then conflicting flags, then release.
      nf[0] = 1'b0;
      beat(0, 32'h33333333, 4'hF, 1'b0, 1'b0);
      beat(0, 32'h44444444, 4'hF, 1'b1, 1'b1);
      idle(0);
      @(negedge clk);
      hold = fd2;
      chk("stall_word", hold, {1'b1, 1'b1, 8'hFF, 64'h44444444_33333333});
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_stb", i),  stb[0], 0);
         chk($sformatf("stall%0d_rdy", i),  rdy[0], 0);
         chk($sformatf("stall%0d_data", i), fd2,    hold);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      full[0] = 1'b1;
      nf[0]   = 1'b1;
      @(negedge clk);
      chk("conflict_stb", stb[0], 0);
      chk("conflict_rdy", rdy[0], 0);
      @(posedge clk);
      #1;
      full[0] = 1'b0;
      @(negedge clk);
      chk("release_stb", stb[0], 1);
      chk("release_rdy", rdy[0], 1);
      @(posedge clk);
      #1;
      cyc_n(1);
      chk("release_cnt", cnt[0], 2);

      // Continuous stream: 100 beats in 100 cycles give 50 words.
      w0 = words[0];
      st = cyc;
      for (int i = 0; i < 100; i++) begin
         beat(0, {16'hC0DE, 16'(i)}, 4'hF, (i % 10) == 9, 1'b0);
      end
      en = cyc;
      idle(0);
      cyc_n(3);
      chk("cont_cycles", en - st, 100);
      chk("cont_words",  words[0] - w0, 50);
      chk("cont_pkts",   cnt[0], 12);

      // Reset with half a word pending: it must vanish.
      beat(0, 32'h55555555, 4'hF, 1'b0, 1'b0);
      idle(0);
      rst = 1'b1;
      model_clear(0);
      model_clear(1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_cnt",  cnt[0], 0);
      chk("midrst_rdy",  rdy[0], 1);
      chk("midrst_stb",  stb[0], 0);
      chk("midrst_data", fd2,    0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      w0 = words[0];
      beat(0, 32'h66666666, 4'hF, 1'b0, 1'b0);
      beat(0, 32'h77777777, 4'hF, 1'b1, 1'b0);
      idle(0);
      cyc_n(2);
      chk("postrst_words", words[0] - w0, 1);
      chk("postrst_word",  last_w0, {1'b0, 1'b1, 8'hFF, 64'h77777777_66666666});
      chk("postrst_cnt",   cnt[0], 1);

      cyc_n(3);
      chk("sb0_drained", q0.size(), 0);
      chk("sb1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
